// File: rtl/fp_stimulus_sequencer_pkg.sv
// Shared types and constants for the FPU stimulus sequencer: FSM states,
// the LFSR feedback mask and the special-operand table.
package fpu_tb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    localparam logic [31:0] SPC_POS_ZERO   = 32'h0000_0000;
    localparam logic [31:0] SPC_NEG_ZERO   = 32'h8000_0000;
    localparam logic [31:0] SPC_POS_INF    = 32'h7F80_0000;
    localparam logic [31:0] SPC_NEG_INF    = 32'hFF80_0000;
    localparam logic [31:0] SPC_QNAN       = 32'h7FC0_0000;
    localparam logic [31:0] SPC_MIN_DENORM = 32'h0000_0001;
    localparam logic [31:0] SPC_MAX_NORMAL = 32'h7F7F_FFFF;
    localparam logic [31:0] SPC_ONE        = 32'h3F80_0000;

    function automatic logic [31:0] special_operand(input logic [2:0] idx);
        logic [31:0] val;
        val = SPC_POS_ZERO;
        case (idx)
            3'd0: val = SPC_POS_ZERO;
            3'd1: val = SPC_NEG_ZERO;
            3'd2: val = SPC_POS_INF;
            3'd3: val = SPC_NEG_INF;
            3'd4: val = SPC_QNAN;
            3'd5: val = SPC_MIN_DENORM;
            3'd6: val = SPC_MAX_NORMAL;
            3'd7: val = SPC_ONE;
            default: val = SPC_POS_ZERO;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/fp_stimulus_sequencer_if.sv
// Operand/handshake bundle between the stimulus sequencer (master) and the
// FPU plus pattern logger (slave).
interface fp_stimulus_sequencer_if;
    logic        Enable;
    logic        Done;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  Sel;
    logic [1:0]  round;
    logic        start;
    logic        FIN;
    logic [15:0] VecCount;
    logic        Timeout;

    modport master (
        input  Enable, Done,
        output A, B, Sel, round, start, FIN, VecCount, Timeout
    );

    modport slave (
        output Enable, Done,
        input  A, B, Sel, round, start, FIN, VecCount, Timeout
    );
endinterface

// File: rtl/fp_stimulus_sequencer_lfsr.sv
// 32-bit Galois LFSR that advances only when step is high; an all-zero seed
// would lock up, so it is replaced by 1.
module lfsr32
    import fpu_tb_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001,
    parameter logic [31:0] MASK = LFSR_MASK
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        step,
    output logic [31:0] q
);
    localparam logic [31:0] SEED_SAFE = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            q <= SEED_SAFE;
        end else if (step) begin
            q <= (q >> 1) ^ (q[0] ? MASK : 32'h0);
        end
    end
endmodule

// File: rtl/fp_stimulus_sequencer.sv
// Issues LFSR-generated operand vectors to the FPU, one per Done (or timeout),
// and raises FIN after NUM_VECTORS. Optional macro: SPECIAL_OPERANDS_EN.
module fp_stimulus_sequencer
    import fpu_tb_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 1024,
    parameter logic [31:0] SEED_A      = 32'h1234_5678,
    parameter logic [31:0] SEED_B      = 32'h8765_4321,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                   Clock,
    input  logic                   Reset,
    fp_stimulus_sequencer_if.master bus
);
    localparam int unsigned     WCW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0]  WAIT_LAST  = WCW'(TIMEOUT - 1);
    localparam logic [15:0]     LAST_COUNT = 16'(NUM_VECTORS - 1);

    seq_state_t     state_reg, state_next;
    logic [WCW-1:0] wait_cnt_reg;
    logic [15:0]    vec_count_reg;
    logic [31:0]    a_reg, b_reg;
    logic [1:0]     sel_reg, round_reg;
    logic           start_reg, timeout_reg;

    logic           issue, step, wait_inc, timeout_hit, fin;
    logic [31:0]    lfsr_a_q, lfsr_b_q, a_issue;

    lfsr32 #(.SEED(SEED_A), .MASK(LFSR_MASK)) u_lfsr_a (
        .Clock(Clock), .Reset(Reset), .step(step), .q(lfsr_a_q)
    );

    lfsr32 #(.SEED(SEED_B), .MASK(LFSR_MASK)) u_lfsr_b (
        .Clock(Clock), .Reset(Reset), .step(step), .q(lfsr_b_q)
    );

`ifdef SPECIAL_OPERANDS_EN
    // Every 8th vector swaps A for a corner-case operand; B stays random.
    assign a_issue = (vec_count_reg[2:0] == 3'b111) ? special_operand(vec_count_reg[5:3])
                                                    : lfsr_a_q;
`else
    assign a_issue = lfsr_a_q;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.Enable) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (bus.Done || (wait_cnt_reg == WAIT_LAST)) state_next = NEXT;
            NEXT: begin
                if (vec_count_reg == LAST_COUNT) state_next = DONE;
                else if (bus.Enable)             state_next = ISSUE;
                else                             state_next = IDLE;
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue       = 1'b0;
        step        = 1'b0;
        wait_inc    = 1'b0;
        timeout_hit = 1'b0;
        fin         = 1'b0;
        case (state_reg)
            ISSUE: issue = 1'b1;
            WAIT: begin
                // A Done arriving on the last wait cycle wins over the timeout.
                if (!bus.Done) begin
                    if (wait_cnt_reg == WAIT_LAST) timeout_hit = 1'b1;
                    else                           wait_inc    = 1'b1;
                end
            end
            NEXT:  step = 1'b1;
            DONE:  fin  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wait_cnt_reg  <= '0;
            vec_count_reg <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            sel_reg       <= '0;
            round_reg     <= '0;
            start_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            start_reg <= issue;
            if (issue) begin
                a_reg        <= a_issue;
                b_reg        <= lfsr_b_q;
                sel_reg      <= vec_count_reg[1:0];
                round_reg    <= vec_count_reg[3:2];
                wait_cnt_reg <= '0;
            end else if (wait_inc) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            if (timeout_hit) timeout_reg <= 1'b1;
            if (step)        vec_count_reg <= vec_count_reg + 16'd1;
        end
    end

    assign bus.A        = a_reg;
    assign bus.B        = b_reg;
    assign bus.Sel      = sel_reg;
    assign bus.round    = round_reg;
    assign bus.start    = start_reg;
    assign bus.FIN      = fin;
    assign bus.VecCount = vec_count_reg;
    assign bus.Timeout  = timeout_reg;
endmodule
